// File: rtl/dp_rs_pkg.sv
// ============================================================================
// dp_rs_pkg : shared widths, FU-type encodings and slot payload type
// Revision  : 1.0
// ============================================================================
`default_nettype none

package dp_rs_pkg;

   localparam int ROB_ENTRY_WIDTH = 4;
   localparam int XLEN            = 32;

   // FU-type codes used by the top-level dp_valid decode
   typedef enum logic [2:0] {
      FU_NONE = 3'd0,
      FU_ALU  = 3'd1,
      FU_MEM  = 3'd2,
      FU_BRA  = 3'd3,
      FU_MUL  = 3'd4
   } fu_type_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [1:0]      opa_sel;
      logic [1:0]      opb_sel;
      logic [3:0]      alu_ctrl;
      logic [3:0]      mem_ctrl;
      logic [3:0]      bra_ctrl;
      logic [XLEN-1:0] imm;
   } rs_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/dp_rs_if.sv
// ============================================================================
// dp_rs_if : dispatch, CDB and issue bundle of the reservation station
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dp_rs_if
   import dp_rs_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int ROB_W   = ROB_ENTRY_WIDTH
);
   localparam int CNT_W = $clog2(ENTRIES) + 1;

   logic             flush;
   logic             dp_valid;
   logic [31:0]      PC_DP;
   logic [6:0]       OpCode_DP;
   logic [1:0]       OpASel_DP, OpBSel_DP;
   logic [3:0]       ALUCtrl_DP, MemCtrl_DP, BRACtrl_DP;
   logic [31:0]      Imm_DP;
   logic [ROB_W-1:0] ROB_dest_DP;
   logic [31:0]      OpAValue_DP, OpBValue_DP;
   logic [ROB_W-1:0] OpA_ROB_index_DP, OpB_ROB_index_DP;
   logic             cdb_valid;
   logic [ROB_W-1:0] cdb_rob;
   logic [31:0]      cdb_value;
   logic             rs_full;
   logic [CNT_W-1:0] rs_count;
   logic             issue_valid, issue_ready;
   logic [31:0]      issue_PC;
   logic [6:0]       issue_OpCode;
   logic [1:0]       issue_OpASel, issue_OpBSel;
   logic [3:0]       issue_ALUCtrl, issue_MemCtrl, issue_BRACtrl;
   logic [31:0]      issue_Imm;
   logic [ROB_W-1:0] issue_ROB_dest;
   logic [31:0]      issue_OpA, issue_OpB;

   modport slave (
      input  flush, dp_valid, PC_DP, OpCode_DP, OpASel_DP, OpBSel_DP,
             ALUCtrl_DP, MemCtrl_DP, BRACtrl_DP, Imm_DP, ROB_dest_DP,
             OpAValue_DP, OpBValue_DP, OpA_ROB_index_DP, OpB_ROB_index_DP,
             cdb_valid, cdb_rob, cdb_value, issue_ready,
      output rs_full, rs_count, issue_valid, issue_PC, issue_OpCode,
             issue_OpASel, issue_OpBSel, issue_ALUCtrl, issue_MemCtrl,
             issue_BRACtrl, issue_Imm, issue_ROB_dest, issue_OpA, issue_OpB
   );

   modport master (
      output flush, dp_valid, PC_DP, OpCode_DP, OpASel_DP, OpBSel_DP,
             ALUCtrl_DP, MemCtrl_DP, BRACtrl_DP, Imm_DP, ROB_dest_DP,
             OpAValue_DP, OpBValue_DP, OpA_ROB_index_DP, OpB_ROB_index_DP,
             cdb_valid, cdb_rob, cdb_value, issue_ready,
      input  rs_full, rs_count, issue_valid, issue_PC, issue_OpCode,
             issue_OpASel, issue_OpBSel, issue_ALUCtrl, issue_MemCtrl,
             issue_BRACtrl, issue_Imm, issue_ROB_dest, issue_OpA, issue_OpB
   );

endinterface

`default_nettype wire

// File: rtl/rs_pick.sv
// ============================================================================
// rs_pick : lowest-index find-first over a request vector
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan downward so the last hit written is the lowest index
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dp_rs.sv
// ============================================================================
// dp_rs : reservation station with CDB wakeup and lowest-index issue pick
// Revision: 1.0
// ============================================================================
`default_nettype none

module dp_rs
   import dp_rs_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int ROB_W   = ROB_ENTRY_WIDTH
) (
   input  logic   clk,
   input  logic   rst,
   dp_rs_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   logic [ENTRIES-1:0] free_vec, ready_vec;
   logic               free_found, ready_found;
   logic [IDX_W-1:0]   free_idx, ready_idx;
   logic               full, dispatch_ok, issue_fire;
   logic [CNT_W-1:0]   count_q, count_d;
   rs_ctrl_t           dp_ctrl;
   logic [ROB_W-1:0]   dp_qa, dp_qb;
   logic [31:0]        dp_va, dp_vb;
   rs_ctrl_t           ctrl_arr [ENTRIES];
   logic [ROB_W-1:0]   dest_arr [ENTRIES];
   logic [31:0]        va_arr   [ENTRIES];
   logic [31:0]        vb_arr   [ENTRIES];

   assign dp_ctrl = '{pc: bus.PC_DP, opcode: bus.OpCode_DP, opa_sel: bus.OpASel_DP,
                      opb_sel: bus.OpBSel_DP, alu_ctrl: bus.ALUCtrl_DP,
                      mem_ctrl: bus.MemCtrl_DP, bra_ctrl: bus.BRACtrl_DP, imm: bus.Imm_DP};

   // Operand already on the CDB while dispatching is captured directly
   always_comb begin
      dp_qa = bus.OpA_ROB_index_DP;
      dp_va = bus.OpAValue_DP;
      dp_qb = bus.OpB_ROB_index_DP;
      dp_vb = bus.OpBValue_DP;
      if (bus.cdb_valid && dp_qa != '0 && dp_qa == bus.cdb_rob) begin
         dp_qa = '0;
         dp_va = bus.cdb_value;
      end
      if (bus.cdb_valid && dp_qb != '0 && dp_qb == bus.cdb_rob) begin
         dp_qb = '0;
         dp_vb = bus.cdb_value;
      end
   end

   assign full        = (count_q == CNT_W'(ENTRIES));
   assign dispatch_ok = bus.dp_valid && !full && !bus.flush && free_found;
   assign issue_fire  = ready_found && bus.issue_ready && !bus.flush;

   rs_pick #(.N(ENTRIES), .W(IDX_W)) u_pick_free (
      .req(free_vec), .found(free_found), .idx(free_idx)
   );
   rs_pick #(.N(ENTRIES), .W(IDX_W)) u_pick_ready (
      .req(ready_vec), .found(ready_found), .idx(ready_idx)
   );

   for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
      logic             valid_q, valid_d;
      rs_ctrl_t         ctrl_q, ctrl_d;
      logic [ROB_W-1:0] dest_q, dest_d, qa_q, qa_d, qb_q, qb_d;
      logic [31:0]      va_q, va_d, vb_q, vb_d;
      logic             alloc, leave;

      assign alloc = dispatch_ok && (free_idx == IDX_W'(i));
      assign leave = issue_fire && (ready_idx == IDX_W'(i));

      always_comb begin
         valid_d = valid_q;
         ctrl_d  = ctrl_q;
         dest_d  = dest_q;
         qa_d    = qa_q;
         qb_d    = qb_q;
         va_d    = va_q;
         vb_d    = vb_q;
         if (bus.flush) begin
            valid_d = 1'b0;
         end else begin
            if (valid_q && bus.cdb_valid && qa_q != '0 && qa_q == bus.cdb_rob) begin
               qa_d = '0;
               va_d = bus.cdb_value;
            end
            if (valid_q && bus.cdb_valid && qb_q != '0 && qb_q == bus.cdb_rob) begin
               qb_d = '0;
               vb_d = bus.cdb_value;
            end
            if (leave) valid_d = 1'b0;
            if (alloc) begin
               valid_d = 1'b1;
               ctrl_d  = dp_ctrl;
               dest_d  = bus.ROB_dest_DP;
               qa_d    = dp_qa;
               va_d    = dp_va;
               qb_d    = dp_qb;
               vb_d    = dp_vb;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            dest_q  <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
            va_q    <= '0;
            vb_q    <= '0;
         end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
         end
      end

      assign free_vec[i]  = !valid_q;
      assign ready_vec[i] = valid_q && qa_q == '0 && qb_q == '0;
      assign ctrl_arr[i]  = ctrl_q;
      assign dest_arr[i]  = dest_q;
      assign va_arr[i]    = va_q;
      assign vb_arr[i]    = vb_q;
   end

   always_comb begin
      count_d = count_q;
      if (bus.flush)                     count_d = '0;
      else if (dispatch_ok && !issue_fire) count_d = count_q + CNT_W'(1);
      else if (!dispatch_ok && issue_fire) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign bus.rs_full     = full;
   assign bus.rs_count    = count_q;
   assign bus.issue_valid = ready_found;

   always_comb begin
      bus.issue_PC       = '0;
      bus.issue_OpCode   = '0;
      bus.issue_OpASel   = '0;
      bus.issue_OpBSel   = '0;
      bus.issue_ALUCtrl  = '0;
      bus.issue_MemCtrl  = '0;
      bus.issue_BRACtrl  = '0;
      bus.issue_Imm      = '0;
      bus.issue_ROB_dest = '0;
      bus.issue_OpA      = '0;
      bus.issue_OpB      = '0;
      if (ready_found) begin
         bus.issue_PC       = ctrl_arr[ready_idx].pc;
         bus.issue_OpCode   = ctrl_arr[ready_idx].opcode;
         bus.issue_OpASel   = ctrl_arr[ready_idx].opa_sel;
         bus.issue_OpBSel   = ctrl_arr[ready_idx].opb_sel;
         bus.issue_ALUCtrl  = ctrl_arr[ready_idx].alu_ctrl;
         bus.issue_MemCtrl  = ctrl_arr[ready_idx].mem_ctrl;
         bus.issue_BRACtrl  = ctrl_arr[ready_idx].bra_ctrl;
         bus.issue_Imm      = ctrl_arr[ready_idx].imm;
         bus.issue_ROB_dest = dest_arr[ready_idx];
         bus.issue_OpA      = va_arr[ready_idx];
         bus.issue_OpB      = vb_arr[ready_idx];
      end
   end

endmodule

`default_nettype wire
